alu_cmd_sequencer: RTL
======================

// Module: alu_cmd_sequencer
// PURPOSE
//  Command-side controller that drives the 4-bit ALU: accepts (op, operand, repeat) commands over
//  valid/ready, feeds the ALU with accumulator as A and operand as B, writes f back into the
//  accumulator once per cycle for the requested iteration count, then returns the result over a
//  valid/ready response channel. Sits between the command source and the combinational ALU.
// PARAMETERS
//  WIDTH  4  datapath width; must match the ALU (4)
//  REP_W  4  width of the repeat-count field
// PORTS
//  clk          in   1      system clock, all state updates on rising edge
//  rst_n        in   1      synchronous reset, active low
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      sequencer can accept a command
//  cmd_load     in   1      1: load accumulator with cmd_operand (op/rep ignored)
//  cmd_op       in   2      ALU op: 00 add, 10 sub, 11 shift, 01 and
//  cmd_operand  in   WIDTH  B operand (or load value)
//  cmd_rep      in   REP_W  iteration count; 0 treated as 1
//  rsp_valid    out  1      response present
//  rsp_ready    in   1      response consumer ready
//  rsp_data     out  WIDTH  accumulator value at completion
//  rsp_zero     out  1      rsp_data == 0
//  alu_op       out  2      to ALU alu_op
//  alu_a        out  WIDTH  to ALU a (= accumulator)
//  alu_b        out  WIDTH  to ALU b (= latched operand)
//  alu_f        in   WIDTH  from ALU f (combinational result)
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  - Single clock, synchronous active-low reset; one clock domain.
//  - Reset: state IDLE, acc=0, op_q=00, operand_q=0, iter_cnt=0; rsp_valid=0, rsp_data=0,
//    rsp_zero=0 (acc is 0 but rsp_zero gated by rsp_valid), busy=0. cmd_ready=0 while rst_n=0.
//  - alu_a=acc, alu_b=operand_q, alu_op=op_q, all straight from registers (no comb path from cmd_*).
//  - FSM IDLE -> EXEC -> RESP -> IDLE; load path IDLE -> RESP.
//  - IDLE: cmd_ready=1. Accept on cmd_valid&&cmd_ready edge:
//      load: acc<=cmd_operand, go RESP.
//      else: op_q<=cmd_op, operand_q<=cmd_operand, iter_cnt<=(cmd_rep==0)?1:cmd_rep, go EXEC.
//  - EXEC: each cycle acc<=alu_f, iter_cnt<=iter_cnt-1; when iter_cnt==1 go RESP. cmd_ready=0.
//  - RESP: rsp_valid=1, rsp_data=acc, rsp_zero=(acc==0); held stable until rsp_valid&&rsp_ready,
//    then IDLE. Next command accepted no earlier than the cycle after the response handshake.
//  - Latency (accept edge to rsp_valid high): load 1 cycle; op with N iterations N+1 cycles.
//  - Arithmetic entirely in the ALU; results modulo 2^WIDTH, carry discarded, acc wraps silently.
//  - cmd_valid while cmd_ready=0 is ignored (not queued); command fields sampled only at accept.
//  - Reset asserted mid-EXEC or mid-RESP: command abandoned, no response, acc cleared to 0.
//  - acc persists between commands (chaining); only reset or load changes it outside EXEC.
// TESTING (bench instantiates this block with the team ALU)
//  1. Reset, load 4'h5 -> rsp_valid 1 cycle after accept, rsp_data=5, rsp_zero=0.
//  2. acc=5, op=00 operand=3 rep=1 -> rsp_data=8 after 2 cycles; alu_a=5,alu_b=3 during EXEC.
//  3. acc=3, op=00 operand=5 rep=4 -> rsp_data=4'h7 (23 mod 16), rsp_valid 5 cycles after accept.
//  4. acc=2, op=10 operand=3 rep=0 -> rsp_data=4'hF; then op=01 operand=0 -> rsp_data=0, rsp_zero=1.
//  5. RESP with rsp_ready=0 for 5 cycles, cmd_valid=1 throughout -> rsp_data stable, cmd_ready=0,
//     command not accepted until cycle after rsp handshake.
//  6. op=00 operand=1 rep=8, rst_n low on 3rd EXEC cycle -> IDLE, acc=0, rsp_valid never asserted.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 4-bit ALU: accepts commands, iterates the
// accumulator through the ALU and returns the result over valid/ready.
module alu_cmd_sequencer #(
   parameter int WIDTH = 4,
   parameter int REP_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_load,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_operand,
   input  logic [REP_W-1:0] cmd_rep,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_zero,
   output logic [1:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_f,
   output logic             busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] acc;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] operand_q;
   logic [REP_W-1:0] iter_cnt;
   logic             cmd_fire;
   logic             rsp_fire;
   logic             last_iter;

   assign cmd_ready = rst_n && (state == IDLE);
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign rsp_valid = (state == RESP);
   assign rsp_fire  = rsp_valid && rsp_ready;
   assign last_iter = (iter_cnt == REP_W'(1));

   // Response fields are gated so nothing leaks out before a result exists
   assign rsp_data = rsp_valid ? acc : '0;
   assign rsp_zero = rsp_valid && (acc == '0);
   assign busy     = (state != IDLE);

   assign alu_a  = acc;
   assign alu_b  = operand_q;
   assign alu_op = op_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         op_q      <= 2'b00;
         operand_q <= '0;
         iter_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_fire) begin
                  if (cmd_load) begin
                     acc   <= cmd_operand;
                     state <= RESP;
                  end else begin
                     op_q      <= cmd_op;
                     operand_q <= cmd_operand;
                     iter_cnt  <= (cmd_rep == '0) ? REP_W'(1) : cmd_rep;
                     state     <= EXEC;
                  end
               end
            end
            EXEC: begin
               acc      <= alu_f;
               iter_cnt <= iter_cnt - REP_W'(1);
               if (last_iter) begin
                  state <= RESP;
               end
            end
            RESP: begin
               if (rsp_fire) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
